// File: rtl/sipp_rf_write_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// sipp_rf_write_scheduler_pkg
// Shared definitions for the SIPP register-file write scheduler slice.
//   sched_state_e : scheduler FSM states (ARB = serving requesters,
//                   CLEAR = sweeping zeros through every entry)
//   REQ_A / REQ_B : requester identifiers, also used as the last-grant value
//   req_onehot()  : maps a requester id onto its one-hot grant bit
// ---------------------------------------------------------------------------
package sipp_rf_write_scheduler_pkg;

    typedef enum logic {
        ARB   = 1'b0,
        CLEAR = 1'b1
    } sched_state_e;

    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

    // Grant bit 0 belongs to requester A, bit 1 to requester B.
    function automatic logic [1:0] req_onehot(input logic id);
        return (id == REQ_A) ? 2'b01 : 2'b10;
    endfunction

endpackage

// File: rtl/sipp_rf_write_scheduler_rr_arb2.sv
// ---------------------------------------------------------------------------
// sipp_rr_arb2
// Two-input round-robin arbiter (purely combinational).
// Ports:
//   req[1:0]   : request vector, bit 0 = requester A, bit 1 = requester B
//   last_grant : id (REQ_A / REQ_B) of the requester granted most recently
//   grant[1:0] : one-hot grant, all zero when nobody requests
// ---------------------------------------------------------------------------
module sipp_rr_arb2
    import sipp_rf_write_scheduler_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant
);

    // On a tie the requester that was not served last time wins.
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = req_onehot(REQ_A);
            2'b10:   grant = req_onehot(REQ_B);
            2'b11:   grant = (last_grant == REQ_A) ? req_onehot(REQ_B) : req_onehot(REQ_A);
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/sipp_rf_write_scheduler.sv
// ---------------------------------------------------------------------------
// sipp_rf_write_scheduler
// Arbitrates two write requesters onto a single register-file write port and
// can sweep zeros through all N_ELEMENTS entries on request.
// Ports:
//   clk, rst          : clock (rising edge) and synchronous active-low reset
//   a_valid/addr/data : write request from requester A
//   b_valid/addr/data : write request from requester B
//   a_ready, b_ready  : combinational grants; transfer when valid && ready
//   clr_req           : start a clear sweep (ignored while one is running)
//   w_addr/w_data/w_wr: registered register-file write port
//   busy              : registered, high while the sweep state is active
//   clr_done          : registered one-cycle pulse with the final clear write
// ---------------------------------------------------------------------------
module sipp_rf_write_scheduler
    import sipp_rf_write_scheduler_pkg::*;
#(
    parameter int N_ELEMENTS = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  a_valid,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_data,
    output logic                  a_ready,
    input  logic                  b_valid,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_data,
    output logic                  b_ready,
    input  logic                  clr_req,
    output logic [ADDR_WIDTH-1:0] w_addr,
    output logic [DATA_WIDTH-1:0] w_data,
    output logic                  w_wr,
    output logic                  busy,
    output logic                  clr_done
);

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(N_ELEMENTS - 1);

    sched_state_e          state;
    sched_state_e          state_next;
    logic [ADDR_WIDTH-1:0] cnt;
    logic [ADDR_WIDTH-1:0] cnt_next;
    logic                  last_grant;
    logic [1:0]            grant;
    logic                  arb_open;
    logic                  a_fire;
    logic                  b_fire;
    logic                  clr_write;
    logic                  clr_last;

    sipp_rr_arb2 u_arb (
        .req        ({b_valid, a_valid}),
        .last_grant (last_grant),
        .grant      (grant)
    );

    // State, sweep counter and round-robin pointer. The pointer only moves
    // when a grant is actually taken.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ARB;
            cnt        <= '0;
            last_grant <= REQ_B;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (a_fire) begin
                last_grant <= REQ_A;
            end else if (b_fire) begin
                last_grant <= REQ_B;
            end
        end
    end

    // The counter wraps to zero on the final entry so it never passes
    // LAST_IDX even when the address space is larger than the file.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            ARB: begin
                if (clr_req) begin
                    state_next = CLEAR;
                    cnt_next   = '0;
                end
            end
            CLEAR: begin
                if (cnt == LAST_IDX) begin
                    state_next = ARB;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + ADDR_WIDTH'(1);
                end
            end
            default: begin
                state_next = ARB;
                cnt_next   = '0;
            end
        endcase
    end

    // Grants are only offered in ARB, out of reset, and when no clear is
    // being requested (a clear request beats any pending write).
    always_comb begin
        arb_open  = rst && (state == ARB) && !clr_req;
        a_ready   = arb_open && grant[0];
        b_ready   = arb_open && grant[1];
        a_fire    = a_valid && a_ready;
        b_fire    = b_valid && b_ready;
        clr_write = (state == CLEAR);
        clr_last  = (state == CLEAR) && (cnt == LAST_IDX);
    end

    // Registered write port; the address/data hold their last value when
    // no write is issued.
    always_ff @(posedge clk) begin
        if (!rst) begin
            w_wr     <= 1'b0;
            w_addr   <= '0;
            w_data   <= '0;
            busy     <= 1'b0;
            clr_done <= 1'b0;
        end else begin
            w_wr     <= a_fire || b_fire || clr_write;
            busy     <= (state_next == CLEAR);
            clr_done <= clr_last;
            if (clr_write) begin
                w_addr <= cnt;
                w_data <= '0;
            end else if (a_fire) begin
                w_addr <= a_addr;
                w_data <= a_data;
            end else if (b_fire) begin
                w_addr <= b_addr;
                w_data <= b_data;
            end
        end
    end

endmodule

// File: tb/tb_sipp_rf_write_scheduler.sv
// ---------------------------------------------------------------------------
// tb_sipp_rf_write_scheduler
// Directed bench for the write scheduler. Expected writes are queued when a
// grant or clear write is expected and popped when the write port fires.
// ---------------------------------------------------------------------------
module tb_sipp_rf_write_scheduler;

    localparam int N_ELEMENTS = 16;
    localparam int ADDR_WIDTH = 4;
    localparam int DATA_WIDTH = 16;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } wr_t;

    logic                  clk;
    logic                  rst;
    logic                  a_valid;
    logic [ADDR_WIDTH-1:0] a_addr;
    logic [DATA_WIDTH-1:0] a_data;
    logic                  a_ready;
    logic                  b_valid;
    logic [ADDR_WIDTH-1:0] b_addr;
    logic [DATA_WIDTH-1:0] b_data;
    logic                  b_ready;
    logic                  clr_req;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_data;
    logic                  w_wr;
    logic                  busy;
    logic                  clr_done;

    wr_t exp_q[$];
    int  n_checks;
    int  n_fail;

    sipp_rf_write_scheduler #(
        .N_ELEMENTS (N_ELEMENTS),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .a_valid  (a_valid),
        .a_addr   (a_addr),
        .a_data   (a_data),
        .a_ready  (a_ready),
        .b_valid  (b_valid),
        .b_addr   (b_addr),
        .b_data   (b_data),
        .b_ready  (b_ready),
        .clr_req  (clr_req),
        .w_addr   (w_addr),
        .w_data   (w_data),
        .w_wr     (w_wr),
        .busy     (busy),
        .clr_done (clr_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, expv);
        end
    endtask

    // Drive one cycle's inputs just after the rising edge, then move to the
    // falling edge where the combinational grants are stable.
    task automatic applyStimulus(input logic r, input logic clr,
                                 input logic av, input logic [ADDR_WIDTH-1:0] aa, input logic [DATA_WIDTH-1:0] ad,
                                 input logic bv, input logic [ADDR_WIDTH-1:0] ba, input logic [DATA_WIDTH-1:0] bd);
        rst     = r;
        clr_req = clr;
        a_valid = av;
        a_addr  = aa;
        a_data  = ad;
        b_valid = bv;
        b_addr  = ba;
        b_data  = bd;
        @(negedge clk);
    endtask

    // Check grants, queue the write this cycle should produce, then after
    // the edge check busy/clr_done and the write port against the queue.
    task automatic checkOutput(input string tag, input logic exp_ar, input logic exp_br,
                               input logic exp_busy, input logic exp_done,
                               input logic clr_push, input logic [ADDR_WIDTH-1:0] clr_addr);
        wr_t  e;
        logic e_wr;
        checkValue({tag, "_a_ready"}, 32'(a_ready), 32'(exp_ar));
        checkValue({tag, "_b_ready"}, 32'(b_ready), 32'(exp_br));
        if (clr_push) begin
            exp_q.push_back('{addr: clr_addr, data: '0});
        end else if (exp_ar && a_valid) begin
            exp_q.push_back('{addr: a_addr, data: a_data});
        end else if (exp_br && b_valid) begin
            exp_q.push_back('{addr: b_addr, data: b_data});
        end
        @(posedge clk);
        #1;
        checkValue({tag, "_busy"}, 32'(busy), 32'(exp_busy));
        checkValue({tag, "_clr_done"}, 32'(clr_done), 32'(exp_done));
        e_wr = (exp_q.size() != 0);
        checkValue({tag, "_w_wr"}, 32'(w_wr), 32'(e_wr));
        if (e_wr) begin
            e = exp_q.pop_front();
            checkValue({tag, "_w_addr"}, 32'(w_addr), 32'(e.addr));
            checkValue({tag, "_w_data"}, 32'(w_data), 32'(e.data));
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;

        // Reset with a request pending: no grants, everything cleared.
        applyStimulus(1'b0, 1'b0, 1'b1, 4'd7, 16'hBEEF, 1'b1, 4'd8, 16'hCAFE);
        checkOutput("rst0", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        checkValue("rst_w_addr", 32'(w_addr), 32'd0);
        checkValue("rst_w_data", 32'(w_data), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
        checkOutput("rst1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);

        // Single A write, then an idle cycle with no write.
        applyStimulus(1'b1, 1'b0, 1'b1, 4'd3, 16'h1234, 1'b0, 4'd0, 16'h0);
        checkOutput("single_a", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
        checkOutput("idle0", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);

        // Re-reset so the tie-break starts from A again, then four ties.
        applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
        checkOutput("rst2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, 4'd1, 16'h00A1 + 16'(i), 1'b1, 4'd2, 16'h00B2 + 16'(i));
            checkOutput($sformatf("tie%0d", i), (i % 2) == 0, (i % 2) == 1, 1'b0, 1'b0, 1'b0, '0);
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
        checkOutput("idle1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);

        // Lone B request.
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 16'h0, 1'b1, 4'd9, 16'h9999);
        checkOutput("single_b", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);

        // Clear with A held valid; clr_req re-pulsed mid-sweep is ignored.
        applyStimulus(1'b1, 1'b1, 1'b1, 4'd5, 16'h5555, 1'b0, 4'd0, 16'h0);
        checkOutput("clr_start", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
        for (int i = 0; i < N_ELEMENTS; i++) begin
            applyStimulus(1'b1, (i == 3), 1'b1, 4'd5, 16'h5555, 1'b0, 4'd0, 16'h0);
            checkOutput($sformatf("sweep%0d", i), 1'b0, 1'b0, (i != N_ELEMENTS - 1), (i == N_ELEMENTS - 1), 1'b1, 4'(i));
        end
        applyStimulus(1'b1, 1'b0, 1'b1, 4'd5, 16'h5555, 1'b0, 4'd0, 16'h0);
        checkOutput("held_a", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
        checkOutput("idle2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);

        // Sweep aborted by reset at counter 5.
        applyStimulus(1'b1, 1'b1, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
        checkOutput("clr2_start", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
            checkOutput($sformatf("abort_sweep%0d", i), 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'(i));
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
        checkOutput("abort_rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);

        // Back in ARB: first tie goes to A, the next one to B.
        applyStimulus(1'b1, 1'b0, 1'b1, 4'd12, 16'hA00C, 1'b1, 4'd13, 16'hB00D);
        checkOutput("post_abort_tie0", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        applyStimulus(1'b1, 1'b0, 1'b1, 4'd14, 16'hA00E, 1'b1, 4'd15, 16'hB00F);
        checkOutput("post_abort_tie1", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
        checkOutput("idle3", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);

        checkValue("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sipp_rf_write_scheduler.md
SIPP_RF_WRITE_SCHEDULER -- requirements
Module: sipp_rf_write_scheduler

Interface
REQ-001 The block SHALL have parameter N_ELEMENTS, default 16, number of register-file entries swept by a clear.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 4, register address width.
REQ-003 The block SHALL have parameter DATA_WIDTH, default 16, register data width.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-005 The block SHALL have port rst, input, 1, reset, synchronous and active-low (0 = reset).
REQ-006 The block SHALL have ports a_valid, b_valid, input, 1 each, write request from requester A / B.
REQ-007 The block SHALL have ports a_addr, b_addr, input, ADDR_WIDTH each, requested write address.
REQ-008 The block SHALL have ports a_data, b_data, input, DATA_WIDTH each, requested write data.
REQ-009 The block SHALL have ports a_ready, b_ready, output, 1 each, combinational grant; a transfer occurs when valid and ready are both 1.
REQ-010 The block SHALL have port clr_req, input, 1, request to zero all N_ELEMENTS entries.
REQ-011 The block SHALL have ports w_addr (ADDR_WIDTH), w_data (DATA_WIDTH), w_wr (1), outputs, registered drive of the register-file write port.
REQ-012 The block SHALL have port busy, output, 1, registered, high while a clear sweep is in progress.
REQ-013 The block SHALL have port clr_done, output, 1, registered, one-cycle pulse marking the final clear write.

Function
REQ-014 The state machine SHALL have two states: ARB and CLEAR.
REQ-015 In ARB with clr_req=1, both readies SHALL be 0 and the next state SHALL be CLEAR with sweep counter 0; clr_req wins over simultaneous valids.
REQ-016 In ARB with clr_req=0 and exactly one valid, that requester's ready SHALL be 1.
REQ-017 In ARB with clr_req=0 and both valid, ready SHALL go to the requester not granted most recently (round-robin); the other ready SHALL be 0.
REQ-018 The last-grant pointer SHALL update only on an accepted transfer.
REQ-019 An accepted transfer in cycle t SHALL produce w_wr=1 with the granted addr/data in cycle t+1 (1-cycle latency); a new transfer SHALL be accepted every cycle (no bubbles).
REQ-020 w_wr SHALL be 0 in any cycle following a cycle with no accepted transfer and no clear write.
REQ-021 In CLEAR, a_ready and b_ready SHALL be 0, and each cycle SHALL issue one write (next cycle w_wr=1, w_addr=counter, w_data=0), then increment the counter.
REQ-022 When the counter equals N_ELEMENTS-1 in CLEAR, the block SHALL issue that write, pulse clr_done in the same output cycle, and return to ARB.
REQ-023 clr_req in CLEAR SHALL be ignored (no restart, no extension).
REQ-024 busy SHALL be 1 exactly in cycles where the state is CLEAR; for clr_req at cycle t, busy SHALL be high t+1..t+N_ELEMENTS, clear writes SHALL appear at t+2..t+N_ELEMENTS+1, and clr_done at t+N_ELEMENTS+1.
REQ-025 Requests held during CLEAR SHALL be served in ARB from the cycle after the sweep ends; held valid/addr/data are not latched early.
REQ-026 The counter SHALL never exceed N_ELEMENTS-1, including when N_ELEMENTS < 2^ADDR_WIDTH.

Reset
REQ-027 When rst=0 at a rising edge: state ARB, counter 0, last grant = B (so A wins the first tie), w_wr=0, w_addr=0, w_data=0, busy=0, clr_done=0.
REQ-028 Reset asserted mid-sweep SHALL abort the sweep with no further writes and no clr_done pulse.
REQ-029 While rst=0, a_ready and b_ready SHALL be 0.

Structure
REQ-030 State encoding (ARB/CLEAR) and requester-id constants (REQ_A, REQ_B) SHALL live in the shared SIPP package.
REQ-031 The 2-input round-robin grant logic SHALL be a sub-module named sipp_rr_arb2 (inputs req[1:0], last-grant; output one-hot grant).

Verification
REQ-032 Reset, then a_valid=1 (addr 3, data 0x1234) for one cycle -> a_ready=1, next cycle w_wr=1, w_addr=3, w_data=0x1234.
REQ-033 Both valid for 4 cycles (A: addr 1, B: addr 2) -> grants A,B,A,B; w_addr sequence 1,2,1,2 on consecutive cycles.
REQ-034 clr_req at cycle 10 with N_ELEMENTS=16 -> busy cycles 11..26, writes addr 0..15 data 0 at cycles 12..27, clr_done only at 27.
REQ-035 clr_req and a_valid simultaneously, a_valid held -> a_ready=0 until sweep ends, A write appears one cycle after its first ready.
REQ-036 rst=0 at sweep cycle 5 -> w_wr=0 next cycle, no clr_done, state ARB, next tie grants A.
REQ-037 clr_req re-pulsed during CLEAR -> exactly 16 clear writes, one clr_done.
